dmem_ctrl: RTL and testbench

- Data-memory access controller sitting directly downstream of the 5-stage pipeline's MEM stage.
- Consumes the MEM-stage memory request (mem_ren/mem_wen/mem_addr/mem_dout) and runs a req/ack transaction on a variable-latency word-addressed RAM bus.
- Returns read data on mem_din and asserts mem_stall to the pipeline controller so that MEM and all older/younger stages freeze until the access completes.
- Also detects misaligned accesses and bus timeouts.

---
 rtl/dmem_ctrl.sv | 118 +++++++++++
 tb/tb_dmem_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory access controller behind the MEM stage.
// Runs req/ack RAM transactions, stalls the pipeline, flags misalign/timeout.
module dmem_ctrl #(
  parameter int          ADDR_W   = 30,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_dout,
  input  logic              mem_hold,
  output logic [31:0]       mem_din,
  output logic              mem_stall,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic              ram_ack,
  input  logic [31:0]       ram_rdata,
  output logic              align_err,
  output logic              bus_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rdata_q;
  logic             req_any;
  logic             misalign;
  logic             stall_raw;

  assign req_any  = mem_ren | mem_wen;
  assign misalign = mem_addr[1:0] != 2'b00;
  assign mem_din  = rdata_q;

  always_comb begin
    stall_raw = 1'b0;
    unique case (state)
      IDLE:    stall_raw = req_any;
      REQ:     stall_raw = 1'b1;
      default: stall_raw = 1'b0;
    endcase
  end

  // Stall must read low while reset holds, even with a request present.
  assign mem_stall = stall_raw & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata_q   <= '0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            !req_any: begin
              state <= IDLE;
            end
            req_any && misalign: begin
              align_err <= 1'b1;
              if (!mem_wen) rdata_q <= ERR_DATA;
              state <= DONE;
            end
            req_any && !misalign: begin
              ram_addr  <= mem_addr[ADDR_W+1:2];
              ram_we    <= mem_wen;
              ram_wdata <= mem_dout;
              ram_req   <= 1'b1;
              cnt       <= '0;
              state     <= REQ;
            end
            default: state <= IDLE;
          endcase
        end
        REQ: begin
          // An ack arriving on the last allowed cycle beats the timeout.
          unique case (1'b1)
            ram_ack: begin
              ram_req <= 1'b0;
              if (!ram_we) rdata_q <= ram_rdata;
              state <= DONE;
            end
            !ram_ack && (cnt == CNT_LAST): begin
              ram_req <= 1'b0;
              bus_err <= 1'b1;
              if (!ram_we) rdata_q <= ERR_DATA;
              state <= DONE;
            end
            default: cnt <= cnt + CNT_W'(1);
          endcase
        end
        DONE: begin
          if (!mem_hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized scoreboard bench for dmem_ctrl.
// Driver pushes expected results; negedge monitor pops and compares.
module tb_dmem_ctrl;

  localparam int          TO  = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_ren, mem_wen, mem_hold;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic        mem_stall;
  logic        ram_req, ram_we, ram_ack;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        align_err, bus_err;

  dmem_ctrl #(.ADDR_W(30), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_hold(mem_hold), .mem_din(mem_din),
    .mem_stall(mem_stall), .ram_req(ram_req),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_ack(ram_ack),
    .ram_rdata(ram_rdata), .align_err(align_err),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] din;
    int          stall;
    int          reqs;
    logic        aerr;
    logic        berr;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  logic [31:0] m_din;
  logic        m_aerr, m_berr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_din  = '0;
    m_aerr = 1'b0;
    m_berr = 1'b0;
    q.delete();
  endtask

  // Reference: stall length and result follow directly from ack wait count.
  task automatic do_access(input bit we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] rdata,
                           input int wait_n, input int hold_n);
    exp_t e;
    int   reqc = 0;
    int   dj   = -1;
    bit   fin  = 1'b0;
    e.we = we; e.addr = addr; e.wdata = data;
    if (addr[1:0] != 2'b00) begin
      e.stall = 1; e.reqs = 0; m_aerr = 1'b1;
      if (!we) m_din = ERR;
    end else if (wait_n < TO) begin
      e.stall = 2 + wait_n; e.reqs = wait_n + 1;
      if (!we) m_din = rdata;
    end else begin
      e.stall = 1 + TO; e.reqs = TO; m_berr = 1'b1;
      if (!we) m_din = ERR;
    end
    e.din = m_din; e.aerr = m_aerr; e.berr = m_berr;
    q.push_back(e);
    mem_ren  = !we;
    mem_wen  = we;
    mem_addr = addr;
    mem_dout = data;
    mem_hold = (hold_n > 0);
    for (int c = 0; c < TO + 40; c++) begin
      ram_ack   = 1'b0;
      ram_rdata = $urandom;
      #1;
      if (ram_req) begin
        if (reqc == wait_n) begin
          ram_ack   = 1'b1;
          ram_rdata = rdata;
        end
        reqc++;
      end else begin
        ram_ack = 1'($urandom_range(0, 1));
      end
      if (dj < 0 && !mem_stall) dj = 0;
      @(negedge clk);
      if (dj >= 0) begin
        if (dj == hold_n) begin
          fin = 1'b1;
          break;
        end
        dj++;
        mem_hold = (dj < hold_n);
      end
    end
    if (!fin) begin
      n_chk++;
      n_fail++;
      $display("FAIL drv_timeout: addr %h never completed", addr);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ren  = 1'b0;
      mem_wen  = 1'b0;
      mem_hold = 1'($urandom_range(0, 1));
      ram_ack  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  int          run = 0;
  int          breq = 0;
  bit          prev_stall = 1'b0;
  bit          in_done = 1'b0;
  logic [31:0] held_din;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!mon_en || !rst_n) begin
      run = 0; breq = 0; prev_stall = 1'b0; in_done = 1'b0;
    end else begin
      if (ram_req) begin
        breq++;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL bus_unexp: ram_req=1 expected 0");
        end else begin
          chk("ram_addr", 32'(ram_addr), {2'b00, q[0].addr[31:2]});
          chk("ram_we", 32'(ram_we), 32'(q[0].we));
          chk("ram_wdata", ram_wdata, q[0].wdata);
        end
      end
      if (mem_stall) begin
        if (!prev_stall) run = 0;
        run++;
        in_done = 1'b0;
      end else if (prev_stall) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL done_unexp: completion with empty scoreboard");
        end else begin
          e = q.pop_front();
          chk("stall_cycles", 32'(run), 32'(e.stall));
          chk("req_cycles", 32'(breq), 32'(e.reqs));
          chk("mem_din", mem_din, e.din);
          chk("align_err", 32'(align_err), 32'(e.aerr));
          chk("bus_err", 32'(bus_err), 32'(e.berr));
          chk("done_req", 32'(ram_req), 32'd0);
        end
        held_din = mem_din;
        in_done  = 1'b1;
        breq     = 0;
      end else if (in_done && (mem_ren || mem_wen)) begin
        chk("hold_din", mem_din, held_din);
        chk("hold_req", 32'(ram_req), 32'd0);
      end else begin
        in_done = 1'b0;
      end
      prev_stall = mem_stall;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wn;
    rst_n = 1'b0;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_hold = 1'b0;
    mem_addr = '0; mem_dout = '0;
    ram_ack = 1'b0; ram_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_din", mem_din, 32'd0);
    chk("rst_req", 32'(ram_req), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    chk("rst_aerr", 32'(align_err), 32'd0);
    chk("rst_berr", 32'(bus_err), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    do_access(1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, 0);
    do_access(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 3, 0);
    do_access(1'b0, 32'h0000_0100, 32'h0, 32'h0BAD_F00D, 2, 3);
    do_access(1'b0, 32'h0000_0104, 32'h0, 32'h5555_AAAA, TO - 1, 1);
    do_access(1'b0, 32'h0000_0040, 32'h0, 32'h1111_1111, TO + 5, 0);
    do_access(1'b1, 32'h0000_0006, 32'h7777_7777, 32'h0, 0, 0);
    idle(2);

    mon_en   = 1'b0;
    mem_ren  = 1'b1;
    mem_wen  = 1'b0;
    mem_hold = 1'b0;
    mem_addr = 32'h0000_0080;
    ram_ack  = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    chk("pre_rst_req", 32'(ram_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_req", 32'(ram_req), 32'd0);
    chk("async_stall", 32'(mem_stall), 32'd0);
    chk("async_aerr", 32'(align_err), 32'd0);
    chk("async_berr", 32'(bus_err), 32'd0);
    mem_ren = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    do_access(1'b0, 32'h0000_0200, 32'h0, 32'hA5A5_0001, 1, 0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int r;
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      r = $urandom_range(0, 9);
      if (r < 7)      wn = $urandom_range(0, 4);
      else if (r < 9) wn = $urandom_range(5, TO - 1);
      else            wn = TO + 3;
      do_access(1'($urandom_range(0, 1)), a, $urandom, $urandom, wn,
                $urandom_range(0, 3));
      idle($urandom_range(0, 2));
    end

    idle(3);
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
